// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared size encodings, FSM states and default memory depth
//               for the load/store front end.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // CPU access size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Default data memory depth in 32-bit words
    localparam int RAM_SIZE_DEFAULT = 256;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MERGE = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : mau_lane_mux
// Description : Combinational little-endian lane logic. Extracts and
//               sign/zero-extends a load lane, and merges a sub-word store
//               into a previously read memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module mau_lane_mux
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_sext,
    input  logic [31:0] i_ld_word,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_st_base,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword out of the loaded word
    always_comb begin
        w_byte = i_ld_word[7:0];
        case (i_lane)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        // addr[0] never selects a halfword lane
        w_half = i_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    end

    // Extend the selected lane to a full word
    always_comb begin
        o_ld_data = i_ld_word;
        case (i_size)
            SZ_BYTE: o_ld_data = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{i_sext & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

    // Replace only the target lane of the base word with store data
    always_comb begin
        o_st_word = i_st_data;
        case (i_size)
            SZ_BYTE: begin
                o_st_word = i_st_base;
                case (i_lane)
                    2'd0:    o_st_word[7:0]   = i_st_data[7:0];
                    2'd1:    o_st_word[15:8]  = i_st_data[7:0];
                    2'd2:    o_st_word[23:16] = i_st_data[7:0];
                    default: o_st_word[31:24] = i_st_data[7:0];
                endcase
            end
            SZ_HALF: begin
                o_st_word = i_st_base;
                if (i_lane[1]) begin
                    o_st_word[31:16] = i_st_data[15:0];
                end else begin
                    o_st_word[15:0]  = i_st_data[15:0];
                end
            end
            default: o_st_word = i_st_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store front end for a word-only data memory. Converts
//               byte/halfword/word CPU accesses into aligned word reads and
//               writes, extends loads and performs read-modify-write for
//               sub-word stores.
//               Build option: MISALIGN_TRAP_EN - when defined, misaligned
//               halfword/word accesses are rejected with cpu_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int RAM_SIZE = RAM_SIZE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_merge;

    logic        w_accept;
    logic        w_reject;
    logic        w_misalign;
    logic        w_range_err;

    logic [1:0]  w_sel_size;
    logic [1:0]  w_sel_lane;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_word;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((cpu_size == SZ_HALF) && cpu_addr[0]) ||
                        ((cpu_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_range_err = (cpu_addr[31:2] >= 30'(RAM_SIZE));
    assign w_reject    = (cpu_size == SZ_RSVD) || w_misalign || w_range_err;

    // Gating with reset keeps the memory strobes quiet while reset is held
    assign w_accept    = (r_state == IDLE) && cpu_req && reset;

    // Lane logic sees live CPU inputs in IDLE and the latched request in MERGE
    assign w_sel_size  = (r_state == MERGE) ? r_size       : cpu_size;
    assign w_sel_lane  = (r_state == MERGE) ? r_addr[1:0]  : cpu_addr[1:0];
    assign w_sel_wdata = (r_state == MERGE) ? r_wdata      : cpu_wdata;

    mau_lane_mux u_lane_mux (
        .i_size    (w_sel_size),
        .i_lane    (w_sel_lane),
        .i_sext    (cpu_signed),
        .i_ld_word (mem_rdata),
        .i_st_data (w_sel_wdata),
        .i_st_base (r_merge),
        .o_ld_data (w_ld_data),
        .o_st_word (w_st_word)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and memory/CPU strobes
    always_comb begin
        w_next    = r_state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = {r_addr[31:2], 2'b00};
        cpu_ready = 1'b0;
        cpu_err   = 1'b0;
        case (r_state)
            IDLE: begin
                mem_addr = {cpu_addr[31:2], 2'b00};
                if (w_accept) begin
                    if (w_reject) begin
                        w_next = DONE;
                    end else if (!cpu_we) begin
                        mem_rd = 1'b1;
                        w_next = DONE;
                    end else if (cpu_size == SZ_WORD) begin
                        mem_wr    = 1'b1;
                        mem_wdata = cpu_wdata;
                        w_next    = DONE;
                    end else begin
                        mem_rd = 1'b1;
                        w_next = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_wr    = 1'b1;
                mem_wdata = w_st_word;
                w_next    = DONE;
            end
            DONE: begin
                cpu_ready = 1'b1;
                cpu_err   = r_err;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the request, load result and read-modify-write base at acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size    <= 2'b00;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_err     <= 1'b0;
            r_merge   <= 32'h0;
            cpu_rdata <= 32'h0;
        end else if (w_accept) begin
            r_size  <= cpu_size;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_err   <= w_reject;
            if (!w_reject && !cpu_we) begin
                cpu_rdata <= w_ld_data;
            end
            if (!w_reject && cpu_we && (cpu_size != SZ_WORD)) begin
                r_merge <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a word memory
//               and a behavioural load/store reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int RAM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:RAM_WORDS-1];
    logic [31:0] ref_mem [0:RAM_WORDS-1];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'h0;
    logic [31:0] bd_data = 32'h0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_rdata;

    int          res_lat;
    int          res_rd;
    int          res_wr;
    bit          res_both;
    logic [31:0] res_wdata;
    logic [31:0] res_waddr;
    logic [31:0] res_raddr;
    logic        res_err;
    logic [31:0] res_rdata;
    int          res_cyc;

    mem_access_unit #(.RAM_SIZE(RAM_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: combinational read, write on the clock edge
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wr === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
        if (bd_we) mem[bd_idx] <= bd_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit ref_reject(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if ((addr >> 2) >= 32'(RAM_WORDS)) return 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int ref_shift(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return int'(addr % 4) * 8;
        if (size == 2'd1) return int'((addr / 2) % 2) * 16;
        return 0;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [1:0] size);
        if (size == 2'd0) return 32'h0000_00FF;
        if (size == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
        logic [31:0] w, m, v;
        w = ref_mem[addr[9:2]];
        m = ref_mask(size);
        v = (w >> ref_shift(size, addr)) & m;
        if (sgn && size != 2'd2 && (v & ((m >> 1) + 1)) != 0) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_store_word(input logic [1:0] size, input logic [31:0] addr,
                                                   input logic [31:0] wdata);
        logic [31:0] w, m;
        int sh;
        w  = ref_mem[addr[9:2]];
        m  = ref_mask(size);
        sh = ref_shift(size, addr);
        return (w & ~(m << sh)) | ((wdata & m) << sh);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx[7:0]; bd_data = d;
        ref_mem[idx] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one access and record what the memory and CPU sides saw per cycle
    task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input bit scramble);
        res_lat = -1; res_rd = 0; res_wr = 0; res_both = 1'b0;
        res_wdata = 32'h0; res_waddr = 32'h0; res_raddr = 32'h0;
        res_err = 1'b0; res_rdata = 32'h0; res_cyc = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_signed = sgn;
        cpu_addr = addr; cpu_wdata = wdata;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_rd === 1'b1 && mem_wr === 1'b1) res_both = 1'b1;
            if (mem_rd === 1'b1) begin res_rd = res_rd | (1 << k); res_raddr = mem_addr; end
            if (mem_wr === 1'b1) begin
                res_wr = res_wr | (1 << k); res_wdata = mem_wdata; res_waddr = mem_addr;
            end
            if (cpu_ready === 1'b1) begin
                res_lat = k; res_err = cpu_err; res_rdata = cpu_rdata; res_cyc = cyc;
                cpu_req = 1'b0;
                break;
            end
            if (k == 1 && scramble) begin
                cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_size = 2'($urandom);
                cpu_signed = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
            end
        end
        cpu_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0;
        cpu_signed = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        for (int i = 0; i < RAM_WORDS; i++) poke(i, $urandom);
        @(negedge clk);
        total++;
        if ({cpu_ready, cpu_err, mem_rd, mem_wr} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes: got %b want 0000", {cpu_ready, cpu_err, mem_rd, mem_wr});
        end
        total++;
        if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        total++;
        if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        reset = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_byte_loads;
        logic [31:0] a_tab [3];
        logic        s_tab [3];
        logic [31:0] e_tab [3];
        a_tab = '{32'h41, 32'h43, 32'h43};
        s_tab = '{1'b1, 1'b1, 1'b0};
        e_tab = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080};
        poke(32'h10, 32'h80FF_7F01);
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, 2'd0, s_tab[i], a_tab[i], 32'h0, 1'b1);
            total++;
            if (res_rdata !== e_tab[i]) begin
                bad++; $display("FAIL byte_load_%0d: got %h want %h", i, res_rdata, e_tab[i]);
            end
            total++;
            if (res_lat !== 1 || res_rd !== 1 || res_wr !== 0 || res_raddr !== 32'h40) begin
                bad++; $display("FAIL byte_load_seq_%0d: lat=%0d rd=%0d wr=%0d raddr=%h want 1/1/0/40",
                                i, res_lat, res_rd, res_wr, res_raddr);
            end
        end
        exp_rdata = 32'h0000_0080;
    endtask

    task automatic test_half_store;
        poke(32'h10, 32'h1122_3344);
        do_access(1'b1, 2'd1, 1'b0, 32'h42, 32'h1234_BEEF, 1'b1);
        total++;
        if (res_rd !== 1 || res_wr !== 2 || res_lat !== 2 || res_both) begin
            bad++; $display("FAIL half_store_seq: rd=%0d wr=%0d lat=%0d want 1/2/2", res_rd, res_wr, res_lat);
        end
        total++;
        if (res_wdata !== 32'hBEEF_3344 || res_waddr !== 32'h40) begin
            bad++; $display("FAIL half_store_data: got %h@%h want beef3344@40", res_wdata, res_waddr);
        end
        total++;
        if (res_rdata !== exp_rdata || res_err !== 1'b0) begin
            bad++; $display("FAIL half_store_rdata: got %h err=%b want %h err=0", res_rdata, res_err, exp_rdata);
        end
        ref_mem[32'h10] = 32'hBEEF_3344;
        do_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        total++;
        if (res_rdata !== 32'hBEEF_3344) begin
            bad++; $display("FAIL half_store_readback: got %h want beef3344", res_rdata);
        end
        exp_rdata = 32'hBEEF_3344;
    endtask

    task automatic test_word_store;
        do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        ref_mem[4] = 32'hDEAD_BEEF;
        total++;
        if (res_wr !== 1 || res_rd !== 0 || res_lat !== 1 || res_waddr !== 32'h10 ||
            res_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL word_store: wr=%0d rd=%0d lat=%0d addr=%h data=%h want 1/0/1/10/deadbeef",
                            res_wr, res_rd, res_lat, res_waddr, res_wdata);
        end
    endtask

    task automatic test_misalign;
        do_access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        total++;
        if (res_err !== 1'b1 || res_lat !== 1 || res_rd !== 0 || res_wr !== 0 || res_rdata !== exp_rdata) begin
            bad++; $display("FAIL misalign_trap: err=%b lat=%0d rd=%0d wr=%0d rdata=%h want 1/1/0/0/%h",
                            res_err, res_lat, res_rd, res_wr, res_rdata, exp_rdata);
        end
`else
        exp_rdata = 32'hDEAD_BEEF;
        total++;
        if (res_err !== 1'b0 || res_lat !== 1 || res_rdata !== exp_rdata) begin
            bad++; $display("FAIL misalign_load: err=%b lat=%0d rdata=%h want 0/1/%h",
                            res_err, res_lat, res_rdata, exp_rdata);
        end
`endif
    endtask

    task automatic test_errors;
        logic        we_tab [4];
        logic [1:0]  sz_tab [4];
        logic [31:0] a_tab  [4];
        int          first_bad;
        we_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
        sz_tab = '{2'd2, 2'd2, 2'd3, 2'd3};
        a_tab  = '{32'h400, 32'h400, 32'h20, 32'h24};
        for (int i = 0; i < 4; i++) begin
            do_access(we_tab[i], sz_tab[i], 1'b0, a_tab[i], 32'hA5A5_5A5A, 1'b0);
            total++;
            if (res_err !== 1'b1 || res_lat !== 1 || res_rd !== 0 || res_wr !== 0 || res_rdata !== exp_rdata) begin
                bad++; $display("FAIL error_%0d: err=%b lat=%0d rd=%0d wr=%0d rdata=%h want 1/1/0/0/%h",
                                i, res_err, res_lat, res_rd, res_wr, res_rdata, exp_rdata);
            end
        end
        first_bad = -1;
        for (int i = 0; i < RAM_WORDS; i++) if (mem[i] !== ref_mem[i] && first_bad < 0) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL error_mem_intact: word %0d got %h want %h",
                            first_bad, mem[first_bad], ref_mem[first_bad]);
        end
    endtask

    task automatic test_back_to_back;
        int c1;
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        c1 = res_cyc;
        total++;
        if (res_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_first: got %h want deadbeef", res_rdata); end
        do_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
        total++;
        if (res_rdata !== 32'hBEEF_3344 || res_cyc - c1 !== 2) begin
            bad++; $display("FAIL b2b_second: rdata=%h spacing=%0d want beef3344/2", res_rdata, res_cyc - c1);
        end
        exp_rdata = 32'hBEEF_3344;
    endtask

    task automatic test_random;
        logic [1:0]  size;
        logic        we, sgn, rej;
        logic [31:0] addr, wdata, exp_w;
        int          r, idx, exp_lat, exp_rd, exp_wr, first_bad;
        for (int n = 0; n < 80; n++) begin
            r    = int'($urandom % 8);
            size = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            we   = 1'($urandom); sgn = 1'($urandom);
            idx  = ($urandom % 16 == 0) ? 256 + int'($urandom % 1024) : int'($urandom % 64);
            addr = 32'(idx) * 4 + ($urandom % 4);
            wdata = $urandom;
            rej     = ref_reject(size, addr);
            exp_lat = (!rej && we && size != 2'd2) ? 2 : 1;
            exp_rd  = rej ? 0 : (!we || size != 2'd2) ? 1 : 0;
            exp_wr  = (rej || !we) ? 0 : (size == 2'd2) ? 1 : 2;
            exp_w   = (rej || !we) ? 32'h0 : ref_store_word(size, addr, wdata);
            if (!rej && !we) exp_rdata = ref_load(size, sgn, addr);
            do_access(we, size, sgn, addr, wdata, 1'($urandom));
            if (!rej && we) ref_mem[addr[9:2]] = exp_w;
            total++;
            if (res_lat !== exp_lat || res_err !== rej || res_rd !== exp_rd || res_wr !== exp_wr || res_both) begin
                bad++; $display("FAIL rand_%0d_seq: lat=%0d err=%b rd=%0d wr=%0d want %0d/%b/%0d/%0d (sz=%0d we=%b a=%h)",
                                n, res_lat, res_err, res_rd, res_wr, exp_lat, rej, exp_rd, exp_wr, size, we, addr);
            end
            total++;
            if (res_rdata !== exp_rdata) begin
                bad++; $display("FAIL rand_%0d_rdata: got %h want %h (sz=%0d s=%b a=%h)",
                                n, res_rdata, exp_rdata, size, sgn, addr);
            end
            if (exp_wr != 0) begin
                total++;
                if (res_wdata !== exp_w || res_waddr !== {addr[31:2], 2'b00}) begin
                    bad++; $display("FAIL rand_%0d_wdata: got %h@%h want %h@%h",
                                    n, res_wdata, res_waddr, exp_w, {addr[31:2], 2'b00});
                end
            end
        end
        first_bad = -1;
        for (int i = 0; i < RAM_WORDS; i++) if (mem[i] !== ref_mem[i] && first_bad < 0) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL rand_mem: word %0d got %h want %h", first_bad, mem[first_bad], ref_mem[first_bad]);
        end
    endtask

    task automatic test_reset_merge;
        int ready_seen;
        poke(32'h30, 32'h5566_7788);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd1; cpu_signed = 1'b0;
        cpu_addr = 32'hC2; cpu_wdata = 32'h0000_CAFE;
        @(negedge clk);
        cpu_req = 1'b0;
        total++;
        if (mem_wr !== 1'b1) begin bad++; $display("FAIL rstm_merge_wr: got %b want 1", mem_wr); end
        reset = 1'b0;
        #1;
        total++;
        if (mem_wr !== 1'b0) begin bad++; $display("FAIL rstm_wr_drop: got %b want 0", mem_wr); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({cpu_ready, cpu_err, mem_rd, mem_wr} !== 4'b0000 || cpu_rdata !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL rstm_outputs: strobes=%b rdata=%h wdata=%h want 0000/0/0",
                            {cpu_ready, cpu_err, mem_rd, mem_wr}, cpu_rdata, mem_wdata);
        end
        ready_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) ready_seen++;
        end
        total++;
        if (ready_seen !== 0 || mem[32'h30] !== 32'h5566_7788) begin
            bad++; $display("FAIL rstm_no_write: readies=%0d word=%h want 0/55667788", ready_seen, mem[32'h30]);
        end
        do_access(1'b0, 2'd0, 1'b1, 32'hC3, 32'h0, 1'b0);
        total++;
        if (res_lat !== 1 || res_rdata !== 32'h0000_0055) begin
            bad++; $display("FAIL rstm_idle_load: lat=%0d rdata=%h want 1/00000055", res_lat, res_rdata);
        end
    endtask

    initial begin
        test_reset;
        test_byte_loads;
        test_half_store;
        test_word_store;
        test_misalign;
        test_errors;
        test_back_to_back;
        test_random;
        test_reset_merge;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
